// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
// Pipeline control for the 5-stage RV32I core. Drives the hold (stall*) and
// bubble (flush*) controls of the per-stage pipeline registers, selects EX
// operand forwarding, and runs the MEM-stage data-memory req/ack handshake.
// An unacknowledged memory access freezes the whole pipeline.
//
// Ports:
//   clk, reset                    core clock, synchronous active-high reset
//   rsD, rtD / rsE, rtE           source registers of ID / EX instructions
//   writereg{E,M,W}, regwrite{E,M,W}  destination + write enable per stage
//   memtoregE                     EX instruction is a load
//   pcsrcE                        taken branch/jump resolved in EX
//   memopM, dmem_ack              MEM access pending / memory completes it
//   dmem_req                      data access request
//   stall{F,D,E,M}                hold PC / IF-ID / ID-EX / EX-MEM
//   flush{D,E,M,W}                clear IF-ID / ID-EX / EX-MEM / MEM-WB
//   forwardaE, forwardbE          00 regfile, 01 WB result, 10 MEM aluout
//   mem_err                       sticky memory-timeout flag
//   stall_count                   saturating count of cycles with stallF=1
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access outstanding; a new MEM op is requested combinationally
// WAIT  | access requested earlier, still waiting for dmem_ack
// ---------------------------------------------------------------------------
module hazard_unit #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       writeregE,
    input  logic [4:0]       writeregM,
    input  logic [4:0]       writeregW,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             memtoregE,
    input  logic             pcsrcE,
    input  logic             memopM,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             flushW,
    output logic [1:0]       forwardaE,
    output logic [1:0]       forwardbE,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_count
);

    localparam int              WC_W   = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] TO_CNT = WC_W'(TIMEOUT);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic mstall;
    logic lwstall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            mem_err_q     <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_err_q     <= mem_err_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Next state and wait counter; the counter only runs while in WAIT
    // without an ack and is zero on entry to WAIT and throughout IDLE.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        case (state_q)
            IDLE: begin
                if (memopM && !dmem_ack) state_d = WAIT;
            end
            WAIT: begin
                if (dmem_ack) begin
                    state_d = IDLE;
                end else if (wait_cnt_q == TO_CNT) begin
                    wait_cnt_d = wait_cnt_q;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Set on the same edge the counter reaches TIMEOUT.
        mem_err_d = mem_err_q | (wait_cnt_d == TO_CNT);
    end

    assign mstall  = ((state_q == WAIT) && !dmem_ack) ||
                     ((state_q == IDLE) && memopM && !dmem_ack);
    assign lwstall = memtoregE && regwriteE && (writeregE != 5'd0) &&
                     ((writeregE == rsD) || (writeregE == rtD));

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (regwriteM && (writeregM != 5'd0) && (writeregM == src))
            return 2'b10;
        else if (regwriteW && (writeregW != 5'd0) && (writeregW == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        flushM    = 1'b0;
        flushW    = 1'b0;
        dmem_req  = 1'b0;
        forwardaE = 2'b00;
        forwardbE = 2'b00;
        if (reset) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
            flushW = 1'b1;
        end else begin
            dmem_req  = (state_q == WAIT) || ((state_q == IDLE) && memopM);
            forwardaE = fwd_sel(rsE);
            forwardbE = fwd_sel(rtE);
            if (mstall) begin
                // Freeze everything; the MEM-WB bubble keeps the stalled
                // instruction from being retired twice.
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end else if (pcsrcE) begin
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (lwstall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

    assign stall_count_d = (stallF && (stall_count_q != '1)) ?
                           stall_count_q + CNT_W'(1) : stall_count_q;

    assign mem_err     = mem_err_q;
    assign stall_count = stall_count_q;

endmodule
